// File: rtl/alif_neuron_multichan_if.sv
// Configuration, channel and status bundle for the multi-channel ALIF neuron.
// Master drives inputs and observes outputs; the neuron attaches as slave.
interface alif_neuron_multichan_if #(
  parameter int N_CH     = 4,
  parameter int IN_BITS  = 6,
  parameter int W_BITS   = 4,
  parameter int V_BITS   = 8,
  parameter int CNT_BITS = 4
);
  logic                     enable;
  logic                     params_ready;
  logic                     input_enable;
  logic [N_CH*IN_BITS-1:0]  chan_in;
  logic [N_CH*W_BITS-1:0]   weights;
  logic [V_BITS-1:0]        leak_rate_1;
  logic [V_BITS-1:0]        leak_rate_2;
  logic [CNT_BITS-1:0]      leak_cycles_1;
  logic [CNT_BITS-1:0]      leak_cycles_2;
  logic [CNT_BITS-1:0]      refrac_period;
  logic [V_BITS-1:0]        threshold_min;
  logic                     count_clear;
  logic                     spike_out;
  logic [V_BITS-1:0]        v_mem_out;
  logic [V_BITS-1:0]        threshold_out;
  logic                     refractory;
  logic [15:0]              spike_count;

  modport master (
    output enable, params_ready, input_enable,
    output chan_in, weights,
    output leak_rate_1, leak_rate_2,
    output leak_cycles_1, leak_cycles_2,
    output refrac_period, threshold_min, count_clear,
    input  spike_out, v_mem_out, threshold_out,
    input  refractory, spike_count
  );

  modport slave (
    input  enable, params_ready, input_enable,
    input  chan_in, weights,
    input  leak_rate_1, leak_rate_2,
    input  leak_cycles_1, leak_cycles_2,
    input  refrac_period, threshold_min, count_clear,
    output spike_out, v_mem_out, threshold_out,
    output refractory, spike_count
  );
endinterface

// File: rtl/alif_neuron_multichan.sv
// Multi-channel adaptive LIF neuron: weighted sum, two non-overshooting
// leaks toward threshold/2, refractory period, adaptive threshold, counter.
module alif_neuron_multichan #(
  parameter int N_CH     = 4,
  parameter int IN_BITS  = 6,
  parameter int W_BITS   = 4,
  parameter int V_BITS   = 8,
  parameter int CNT_BITS = 4,
  parameter int THR_UP   = 4,
  parameter int THR_DN   = 1
) (
  input logic                    clk,
  input logic                    reset_n,
  alif_neuron_multichan_if.slave bus
);

  localparam int SUM_W = IN_BITS + W_BITS + $clog2(N_CH) + 1;
  localparam int NV_W  = ((SUM_W > V_BITS) ? SUM_W : V_BITS) + 3;
  localparam int TW    = V_BITS + 2;
  localparam logic signed [NV_W-1:0] VMAX = NV_W'((2**V_BITS) - 1);
  localparam logic [TW-1:0]          TMAX = TW'((2**V_BITS) - 1);

  logic [V_BITS-1:0]   v_q, v_d;
  logic [V_BITS-1:0]   thr_q, thr_d;
  logic [CNT_BITS-1:0] refr_q, refr_d;
  logic [CNT_BITS-1:0] lc1_q, lc1_d;
  logic [CNT_BITS-1:0] lc2_q, lc2_d;
  logic                spk_q, spk_d;
  logic [15:0]         cnt_q, cnt_d;

  logic signed [SUM_W-1:0] prod [N_CH];
  logic signed [SUM_W-1:0] sum;

  for (genvar k = 0; k < N_CH; k++) begin : g_prod
    logic [IN_BITS-1:0] c;
    logic [W_BITS-1:0]  w;
    assign c = bus.chan_in[k*IN_BITS +: IN_BITS];
    assign w = bus.weights[k*W_BITS +: W_BITS];
    assign prod[k] =
      $signed({{(SUM_W-IN_BITS){1'b0}}, c}) *
      $signed({{(SUM_W-W_BITS){w[W_BITS-1]}}, w});
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + prod[i];
    end
  end

  // Step toward eq by r, stopping exactly at eq.
  function automatic logic signed [NV_W-1:0] leak_f(
    input logic signed [NV_W-1:0] v,
    input logic signed [NV_W-1:0] e,
    input logic signed [NV_W-1:0] r,
    input logic                   en
  );
    logic signed [NV_W-1:0] t;
    t = v;
    if (en && (v < e)) begin
      t = ((v + r) > e) ? e : (v + r);
    end else if (en && (v > e)) begin
      t = ((v - r) < e) ? e : (v - r);
    end
    return t;
  endfunction

  logic                   active;
  logic                   apply1, apply2;
  logic signed [NV_W-1:0] eq_s, r1_s, r2_s;
  logic signed [NV_W-1:0] nv0, nv1, nv2;
  logic [V_BITS-1:0]      v_clamp;
  logic                   fire;
  logic [TW-1:0]          thr_up, thr_max, thr_dbl, thr_dn;
  logic [V_BITS-1:0]      thr_inc, thr_dec;

  assign active = bus.enable && bus.params_ready;
  assign apply1 = (lc1_q >= bus.leak_cycles_1);
  assign apply2 = (lc2_q >= bus.leak_cycles_2);

  assign eq_s = $signed({{(NV_W-V_BITS+1){1'b0}}, thr_q[V_BITS-1:1]});
  assign r1_s = $signed({{(NV_W-V_BITS){1'b0}}, bus.leak_rate_1});
  assign r2_s = $signed({{(NV_W-V_BITS){1'b0}}, bus.leak_rate_2});

  assign nv0 = $signed({{(NV_W-V_BITS){1'b0}}, v_q}) +
               $signed({{(NV_W-SUM_W){sum[SUM_W-1]}}, sum});
  assign nv1 = leak_f(nv0, eq_s, r1_s, apply1);
  assign nv2 = leak_f(nv1, eq_s, r2_s, apply2);

  always_comb begin
    v_clamp = nv2[V_BITS-1:0];
    if (nv2 < 0) begin
      v_clamp = '0;
    end else if (nv2 > VMAX) begin
      v_clamp = VMAX[V_BITS-1:0];
    end
  end

  assign fire = (v_clamp >= thr_q) && (v_clamp != '0);

  assign thr_dbl = {1'b0, bus.threshold_min, 1'b0};
  assign thr_max = (thr_dbl > TMAX) ? TMAX : thr_dbl;
  assign thr_up  = {2'b00, thr_q} + TW'(THR_UP);
  assign thr_inc = (thr_up > thr_max) ? thr_max[V_BITS-1:0]
                                      : thr_up[V_BITS-1:0];
  assign thr_dn  = {2'b00, thr_q} - TW'(THR_DN);
  assign thr_dec =
    ($signed(thr_dn) < $signed({2'b00, bus.threshold_min}))
      ? bus.threshold_min : thr_dn[V_BITS-1:0];

  always_comb begin
    v_d    = v_q;
    thr_d  = thr_q;
    refr_d = refr_q;
    lc1_d  = lc1_q;
    lc2_d  = lc2_q;
    spk_d  = 1'b0;
    cnt_d  = cnt_q;
    if (active) begin
      lc1_d = apply1 ? '0 : lc1_q + CNT_BITS'(1);
      lc2_d = apply2 ? '0 : lc2_q + CNT_BITS'(1);
      if (refr_q != '0) begin
        refr_d = refr_q - CNT_BITS'(1);
      end else if (bus.input_enable) begin
        if (fire) begin
          spk_d  = 1'b1;
          v_d    = '0;
          refr_d = bus.refrac_period;
          thr_d  = thr_inc;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else begin
          v_d = v_clamp;
          if (apply1) thr_d = thr_dec;
        end
      end
    end else if (!bus.params_ready) begin
      thr_d = bus.threshold_min;
    end
    if (bus.count_clear) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      thr_q  <= '0;
      refr_q <= '0;
      lc1_q  <= '0;
      lc2_q  <= '0;
      spk_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      thr_q  <= thr_d;
      refr_q <= refr_d;
      lc1_q  <= lc1_d;
      lc2_q  <= lc2_d;
      spk_q  <= spk_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.spike_out     = spk_q;
  assign bus.v_mem_out     = v_q;
  assign bus.threshold_out = thr_q;
  assign bus.refractory    = (refr_q != '0);
  assign bus.spike_count   = cnt_q;

endmodule

// File: tb/tb_alif_neuron_multichan.sv
// Directed bench for alif_neuron_multichan with an expected-output queue.
// Each step pushes the expected post-edge state and pops it after the edge.
module tb_alif_neuron_multichan;

  typedef struct {
    logic [7:0]  v;
    logic [7:0]  thr;
    logic        spk;
    logic        rf;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [15:0] exp_cnt;
  exp_t sbq[$];

  alif_neuron_multichan_if bus ();

  alif_neuron_multichan dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int k, input int c, input int w);
    bus.chan_in[k*6 +: 6] = 6'(c);
    bus.weights[k*4 +: 4] = 4'(w);
  endtask

  task automatic all_ch(input int c, input int w);
    for (int k = 0; k < 4; k++) set_ch(k, c, w);
  endtask

  task automatic step(input int v, input int thr,
                      input logic spk, input logic rf);
    exp_t e;
    if (bus.count_clear) exp_cnt = 16'd0;
    else if (spk && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.v = 8'(v);
    e.thr = 8'(thr);
    e.spk = spk;
    e.rf = rf;
    e.cnt = exp_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("v_mem", 16'(bus.v_mem_out), 16'(e.v));
    chk("threshold", 16'(bus.threshold_out), 16'(e.thr));
    chk("spike", 16'(bus.spike_out), 16'(e.spk));
    chk("refractory", 16'(bus.refractory), 16'(e.rf));
    chk("spike_count", bus.spike_count, e.cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, 16'(bus.v_mem_out), 16'd0);
    chk({tag, "_thr"}, 16'(bus.threshold_out), 16'd0);
    chk({tag, "_spk"}, 16'(bus.spike_out), 16'd0);
    chk({tag, "_ref"}, 16'(bus.refractory), 16'd0);
    chk({tag, "_cnt"}, bus.spike_count, 16'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 16'd0;
    reset_n = 1'b1;
    bus.enable = 1'b0;
    bus.params_ready = 1'b0;
    bus.input_enable = 1'b0;
    bus.chan_in = '0;
    bus.weights = '0;
    bus.leak_rate_1 = 8'd0;
    bus.leak_rate_2 = 8'd0;
    bus.leak_cycles_1 = 4'd15;
    bus.leak_cycles_2 = 4'd15;
    bus.refrac_period = 4'd4;
    bus.threshold_min = 8'd40;
    bus.count_clear = 1'b0;

    #2 reset_n = 1'b0;
    #2 chk_zero("por");
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.enable = 1'b1;
    step(0, 40, 0, 0);
    step(0, 40, 0, 0);

    // integrate 15, 30, spike, refractory for 4 edges
    bus.params_ready = 1'b1;
    bus.input_enable = 1'b1;
    set_ch(0, 5, 3);
    step(15, 40, 0, 0);
    step(30, 40, 0, 0);
    step(0, 44, 1, 1);
    step(0, 44, 0, 1);
    step(0, 44, 0, 1);
    step(0, 44, 0, 1);
    step(0, 44, 0, 0);
    step(15, 44, 0, 0);

    // inhibition drives v down and clamps at 0
    set_ch(0, 10, 2);
    set_ch(1, 10, -3);
    step(5, 44, 0, 0);
    step(0, 44, 0, 0);
    step(0, 44, 0, 0);

    // maximum drive clamps to 255 and spikes
    all_ch(63, 7);
    step(0, 48, 1, 1);
    step(0, 48, 0, 1);
    step(0, 48, 0, 1);
    step(0, 48, 0, 1);
    step(0, 48, 0, 0);
    step(0, 52, 1, 1);
    step(0, 52, 0, 1);

    // asynchronous reset in the middle of a refractory period
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_cnt = 16'd0;
    bus.params_ready = 1'b0;
    all_ch(0, 0);
    step(0, 40, 0, 0);
    step(0, 40, 0, 0);

    // leak 1 stops at eq=20 instead of overshooting
    bus.params_ready = 1'b1;
    set_ch(0, 11, 2);
    step(22, 40, 0, 0);
    set_ch(0, 0, 2);
    bus.leak_rate_1 = 8'd5;
    bus.leak_cycles_1 = 4'd0;
    step(20, 40, 0, 0);
    bus.leak_rate_1 = 8'd0;
    set_ch(0, 5, -2);
    step(10, 40, 0, 0);

    // leak 2 raises by 3 every second cycle and settles at 20
    set_ch(0, 0, 0);
    bus.leak_rate_2 = 8'd3;
    bus.leak_cycles_2 = 4'd1;
    step(13, 40, 0, 0);
    step(13, 40, 0, 0);
    step(16, 40, 0, 0);
    step(16, 40, 0, 0);
    step(19, 40, 0, 0);
    step(19, 40, 0, 0);
    step(20, 40, 0, 0);
    step(20, 40, 0, 0);
    step(20, 40, 0, 0);

    // threshold bounds: reload from new minimum, climb, saturate
    bus.params_ready = 1'b0;
    bus.threshold_min = 8'd200;
    step(20, 200, 0, 0);
    bus.params_ready = 1'b1;
    bus.refrac_period = 4'd0;
    bus.leak_rate_2 = 8'd0;
    all_ch(63, 7);
    bus.count_clear = 1'b1;
    step(0, 204, 1, 0);
    bus.count_clear = 1'b0;
    for (int k = 1; k <= 12; k++) step(0, 204 + 4 * k, 1, 0);
    step(0, 255, 1, 0);
    step(0, 255, 1, 0);

    // decay by one per primary leak down to the minimum
    all_ch(0, 7);
    for (int t = 254; t >= 200; t--) step(0, t, 0, 0);
    step(0, 200, 0, 0);
    step(0, 200, 0, 0);

    // saturating spike counter
    bus.count_clear = 1'b1;
    step(0, 200, 0, 0);
    bus.count_clear = 1'b0;
    all_ch(63, 7);
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_full", bus.spike_count, 16'hFFFF);
    chk("thr_full", 16'(bus.threshold_out), 16'd255);
    exp_cnt = 16'hFFFF;
    step(0, 255, 1, 0);
    step(0, 255, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
